shot_manager: RTL and testbench
===============================

// Module: shot_manager
// PURPOSE
//  Writer side of the shot entity array consumed by draw_controller. Owns MAX_SHOTS packed
//  34-bit shot records: spawns shots at the ship on a fire edge, advances each shot per
//  move_clk tick, wraps at screen edges, expires shots by lifetime, clears shots on kill.
//  Record: [33] valid, [32:30] kind=3'b000, [29:26] 4'b0, [25:16] y, [15:6] x, [5:0] dir.
// PARAMETERS
//  ENTITY_SIZE    34   bits per entity record
//  MAX_SHOTS      3    number of shot slots
//  SHOT_SPEED     2    pixels moved per axis per tick
//  SHOT_LIFETIME  60   ticks a shot stays valid, spawn tick included (>=2)
//  COOLDOWN       8    ticks after a spawn during which fire edges are dropped
//  SCREEN_W       320  x range 0..SCREEN_W-1
//  SCREEN_H       240  y range 0..SCREEN_H-1
// PORTS
//  move_clk     in   1                       game tick clock, all state on posedge
//  reset_n      in   1                       reset, asynchronous, active-high
//  fire         in   1                       fire button level, 1 = pressed
//  ship_x       in   10                      ship x, in range by contract
//  ship_y       in   10                      ship y, in range by contract
//  ship_dir     in   6                       ship direction; [5:3] = octant
//  kill_mask    in   MAX_SHOTS               bit i = clear slot i this tick (collision)
//  shots        out  MAX_SHOTS*ENTITY_SIZE   packed records, slot i at [i*34 +: 34]
//  active_count out  $clog2(MAX_SHOTS+1)     number of valid slots (registered)
//  fire_dropped out  1                       1-tick pulse: fire edge rejected
// BEHAVIOUR
//  Reset (async, active-high): all shots = 0, life counters 0, cooldown 0, fire_q 0,
//   active_count 0, fire_dropped 0. fire held through reset release spawns on first tick.
//  Fire edge: fire_edge = fire & ~fire_q; fire_q <= fire every tick.
//  Velocity from ship_dir[5:3] (screen y grows down), S = SHOT_SPEED:
//   0:(+S,0) 1:(+S,-S) 2:(0,-S) 3:(-S,-S) 4:(-S,0) 5:(-S,+S) 6:(0,+S) 7:(+S,+S).
//   Shot stores its own dir; later ship_dir changes do not affect it.
//  Per slot i, each tick, priority order:
//   1. spawn target: record <= {1,3'b0,4'b0,ship_y,ship_x,ship_dir}, life <= SHOT_LIFETIME;
//      not moved on spawn tick.
//   2. else kill_mask[i]: valid <= 0, all other fields retained, life <= 0.
//   3. else valid & life==1: expire, valid <= 0.
//   4. else valid: life <= life-1; x,y advance by velocity with wrap.
//   5. else: hold.
//  Wrap: 11-bit signed sum; if <0 add SCREEN_W/H; if >=SCREEN_W/H subtract. Single correction.
//  Spawn: accepted iff fire_edge & cooldown==0 & a free slot exists.
//   Free = ~valid | kill_mask; target = lowest-index free slot.
//   A kill and a spawn on the same slot in one tick resolve to the spawn.
//   On accept: cooldown <= COOLDOWN. Otherwise cooldown decrements to 0 and saturates there.
//  fire_dropped <= fire_edge & ~accepted: cooldown active or all slots busy. No queuing of edges.
//  active_count = popcount of the valid bits after the tick's update, registered with the records.
//  Latency: fire edge sampled at tick N -> valid shot visible on shots after tick N.
//  All outputs registered; shots change only on posedge move_clk or reset.
// TESTING
//  1. Reset, ship (100,50) dir 0, fire 0->1 -> slot0 = {1,..,y=50,x=100,dir=0}; next tick x=102.
//  2. Shot dir octant 4 at x=1, S=2 -> after 1 tick x=319. Octant 2 at y=0 -> y=238.
//  3. Spawn, hold fire, no kill -> valid for exactly 60 ticks, cleared on tick 60, active_count 1->0.
//  4. Fire edge 3 ticks after spawn -> fire_dropped=1 for one tick, no new slot.
//     Edge 8+ ticks after spawn -> accepted into slot1.
//  5. Fill all 3 slots, then another edge -> fire_dropped pulse.
//     Edge with kill_mask=3'b010 -> slot1 respawned at ship, active_count stays 3.
//  6. Assert reset_n mid-flight with 2 active shots -> shots=0 and active_count=0 immediately,
//     without a clock edge.

Source files
------------

// File: rtl/shot_manager.sv
// shot_manager: writer side of the shot entity array read by draw_controller.
// Owns MAX_SHOTS packed shot records. It spawns a shot at the ship on a fire
// edge, moves every live shot each tick with screen wrap, expires shots when
// their lifetime runs out, and clears shots named in kill_mask.
// Record layout: [33] valid, [32:30] kind=0, [29:26] 0, [25:16] y, [15:6] x,
// [5:0] dir.
// Ports:
//   move_clk      game tick clock; all state updates on its rising edge
//   reset_n       asynchronous reset, active-high
//   fire          fire button level
//   ship_x/y/dir  ship position and direction; dir[5:3] is the octant
//   kill_mask     bit i clears slot i this tick
//   shots         packed records, slot i at [i*ENTITY_SIZE +: ENTITY_SIZE]
//   active_count  registered count of valid slots
//   fire_dropped  one-tick pulse when a fire edge is rejected
module shot_manager #(
  parameter int ENTITY_SIZE   = 34,
  parameter int MAX_SHOTS     = 3,
  parameter int SHOT_SPEED    = 2,
  parameter int SHOT_LIFETIME = 60,
  parameter int COOLDOWN      = 8,
  parameter int SCREEN_W      = 320,
  parameter int SCREEN_H      = 240
) (
  input  logic                               move_clk,
  input  logic                               reset_n,
  input  logic                               fire,
  input  logic [9:0]                         ship_x,
  input  logic [9:0]                         ship_y,
  input  logic [5:0]                         ship_dir,
  input  logic [MAX_SHOTS-1:0]               kill_mask,
  output logic [MAX_SHOTS*ENTITY_SIZE-1:0]   shots,
  output logic [$clog2(MAX_SHOTS+1)-1:0]     active_count,
  output logic                               fire_dropped
);

  localparam int LW = $clog2(SHOT_LIFETIME + 1);
  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int AW = $clog2(MAX_SHOTS + 1);
  localparam logic signed [10:0] SPD   = 11'(SHOT_SPEED);
  localparam logic signed [10:0] LIM_W = 11'(SCREEN_W);
  localparam logic signed [10:0] LIM_H = 11'(SCREEN_H);

  logic [MAX_SHOTS*ENTITY_SIZE-1:0] shots_q, shots_d;
  logic [LW-1:0]                    life_q [MAX_SHOTS];
  logic [LW-1:0]                    life_d [MAX_SHOTS];
  logic [CW-1:0]                    cooldown_q, cooldown_d;
  logic                             fire_q, fire_d;
  logic [AW-1:0]                    active_count_q, active_count_d;
  logic                             fire_dropped_q, fire_dropped_d;

  logic                             fire_edge;
  logic                             accepted;
  logic                             found;
  logic [MAX_SHOTS-1:0]             spawn_sel;
  logic [ENTITY_SIZE-1:0]           rec;

  function automatic logic signed [10:0] vel_x(input logic [2:0] oct);
    case (oct)
      3'd0, 3'd1, 3'd7: return SPD;
      3'd3, 3'd4, 3'd5: return -SPD;
      default:          return '0;
    endcase
  endfunction

  // Screen y grows downward, so "up" octants carry a negative y step.
  function automatic logic signed [10:0] vel_y(input logic [2:0] oct);
    case (oct)
      3'd1, 3'd2, 3'd3: return -SPD;
      3'd5, 3'd6, 3'd7: return SPD;
      default:          return '0;
    endcase
  endfunction

  // One correction suffices because the step is far smaller than the screen.
  function automatic logic [9:0] wrap(input logic [9:0] p,
                                      input logic signed [10:0] v,
                                      input logic signed [10:0] lim);
    logic signed [10:0] sum;
    sum = $signed({1'b0, p}) + v;
    if (sum < 0)
      sum = sum + lim;
    else if (sum >= lim)
      sum = sum - lim;
    return sum[9:0];
  endfunction

  always_comb begin
    shots_d        = shots_q;
    life_d         = life_q;
    fire_d         = fire;
    active_count_d = '0;
    rec            = '0;
    spawn_sel      = '0;
    found          = 1'b0;
    fire_edge      = fire & ~fire_q;

    // A slot being killed this tick counts as free, so a kill and a spawn
    // on the same slot resolve to the spawn.
    for (int unsigned i = 0; i < MAX_SHOTS; i++) begin
      if (!found && (!shots_q[i*ENTITY_SIZE + 33] || kill_mask[i])) begin
        spawn_sel[i] = 1'b1;
        found        = 1'b1;
      end
    end

    accepted       = fire_edge && (cooldown_q == '0) && found;
    fire_dropped_d = fire_edge && !accepted;
    if (accepted)
      cooldown_d = CW'(COOLDOWN);
    else if (cooldown_q != '0)
      cooldown_d = cooldown_q - CW'(1);
    else
      cooldown_d = cooldown_q;

    for (int unsigned i = 0; i < MAX_SHOTS; i++) begin
      rec = shots_q[i*ENTITY_SIZE +: ENTITY_SIZE];
      if (accepted && spawn_sel[i]) begin
        rec       = {1'b1, 3'b000, 4'b0000, ship_y, ship_x, ship_dir};
        life_d[i] = LW'(SHOT_LIFETIME);
      end else if (kill_mask[i]) begin
        rec[33]   = 1'b0;
        life_d[i] = '0;
      end else if (rec[33] && (life_q[i] == LW'(1))) begin
        rec[33]   = 1'b0;
        life_d[i] = '0;
      end else if (rec[33]) begin
        life_d[i]  = life_q[i] - LW'(1);
        rec[15:6]  = wrap(rec[15:6], vel_x(rec[5:3]), LIM_W);
        rec[25:16] = wrap(rec[25:16], vel_y(rec[5:3]), LIM_H);
      end
      shots_d[i*ENTITY_SIZE +: ENTITY_SIZE] = rec;
      if (rec[33])
        active_count_d = active_count_d + AW'(1);
    end
  end

  always_ff @(posedge move_clk or posedge reset_n) begin
    if (reset_n) begin
      shots_q        <= '0;
      life_q         <= '{default: '0};
      cooldown_q     <= '0;
      fire_q         <= 1'b0;
      active_count_q <= '0;
      fire_dropped_q <= 1'b0;
    end else begin
      shots_q        <= shots_d;
      life_q         <= life_d;
      cooldown_q     <= cooldown_d;
      fire_q         <= fire_d;
      active_count_q <= active_count_d;
      fire_dropped_q <= fire_dropped_d;
    end
  end

  assign shots        = shots_q;
  assign active_count = active_count_q;
  assign fire_dropped = fire_dropped_q;

endmodule

// File: tb/tb_shot_manager.sv
module tb_shot_manager;

  logic        move_clk = 1'b0;
  logic        reset_n;
  logic        fire;
  logic [9:0]  ship_x, ship_y;
  logic [5:0]  ship_dir;
  logic [2:0]  kill_mask;
  logic [101:0] shots;
  logic [1:0]  active_count;
  logic        fire_dropped;

  int total = 0;
  int bad   = 0;
  int tk;

  shot_manager #(
    .ENTITY_SIZE(34), .MAX_SHOTS(3), .SHOT_SPEED(2), .SHOT_LIFETIME(60),
    .COOLDOWN(8), .SCREEN_W(320), .SCREEN_H(240)
  ) dut (
    .move_clk(move_clk), .reset_n(reset_n), .fire(fire),
    .ship_x(ship_x), .ship_y(ship_y), .ship_dir(ship_dir),
    .kill_mask(kill_mask), .shots(shots), .active_count(active_count),
    .fire_dropped(fire_dropped)
  );

  always #5 move_clk = ~move_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] mk(input logic v, input logic [9:0] y,
                                     input logic [9:0] x, input logic [5:0] d);
    return {v, 3'b000, 4'b0000, y, x, d};
  endfunction

  function automatic logic [33:0] slot(input int i);
    return shots[i*34 +: 34];
  endfunction

  // Advance to the negedge following tick t (tick 0 = first edge after release).
  task automatic run_to(input int t);
    while (tk < t) begin
      @(negedge move_clk);
      tk++;
    end
  endtask

  initial begin
    reset_n = 1'b1; fire = 1'b0; kill_mask = '0;
    ship_x = 10'd100; ship_y = 10'd50; ship_dir = 6'd0;
    repeat (2) @(negedge move_clk);
    chk("rst_shots", 64'(shots), 64'd0);
    chk("rst_cnt", 64'(active_count), 64'd0);
    chk("rst_drop", 64'(fire_dropped), 64'd0);
    reset_n = 1'b0;
    tk = -1;

    // Spawn at ship, then one move step.
    fire = 1'b1;
    run_to(0);
    chk("spawn0", 64'(slot(0)), 64'(mk(1'b1, 10'd50, 10'd100, 6'd0)));
    chk("cnt_1", 64'(active_count), 64'd1);
    run_to(1);
    chk("move0", 64'(slot(0)), 64'(mk(1'b1, 10'd50, 10'd102, 6'd0)));
    fire = 1'b0;
    run_to(2);
    fire = 1'b1;
    // Edge during cooldown.
    run_to(3);
    chk("cd_drop", 64'(fire_dropped), 64'd1);
    chk("cd_cnt", 64'(active_count), 64'd1);
    chk("cd_slot1", 64'(slot(1)), 64'd0);
    fire = 1'b0;
    run_to(4);
    chk("drop_pulse", 64'(fire_dropped), 64'd0);
    run_to(8);
    fire = 1'b1;
    // Cooldown is zero at tick 9: accepted into slot1.
    run_to(9);
    chk("cd_accept", 64'(slot(1)), 64'(mk(1'b1, 10'd50, 10'd100, 6'd0)));
    chk("cd_cnt2", 64'(active_count), 64'd2);
    chk("cd_nodrop", 64'(fire_dropped), 64'd0);
    chk("slot0_x9", 64'(slot(0)), 64'(mk(1'b1, 10'd50, 10'd118, 6'd0)));

    // Lifetime: slot0 spawned at tick 0 lives through tick 59.
    run_to(59);
    chk("life_last", 64'(slot(0)), 64'(mk(1'b1, 10'd50, 10'd218, 6'd0)));
    chk("life_cnt2", 64'(active_count), 64'd2);
    run_to(60);
    chk("life_exp", 64'(slot(0) >> 33), 64'd0);
    chk("life_cnt1", 64'(active_count), 64'd1);
    run_to(69);
    chk("life_cnt0", 64'(active_count), 64'd0);
    chk("life_exp1", 64'(slot(1) >> 33), 64'd0);

    // Wrap left edge: octant 4 at x=1.
    fire = 1'b0; ship_x = 10'd1; ship_dir = 6'd32;
    run_to(70);
    fire = 1'b1;
    run_to(71);
    chk("wrap_spawn", 64'(slot(0)), 64'(mk(1'b1, 10'd50, 10'd1, 6'd32)));
    run_to(72);
    chk("wrap_x", 64'(slot(0)), 64'(mk(1'b1, 10'd50, 10'd319, 6'd32)));
    fire = 1'b0; ship_y = 10'd0; ship_dir = 6'd16;
    run_to(79);
    fire = 1'b1;
    // Wrap top edge: octant 2 at y=0.
    run_to(81);
    chk("wrap_y", 64'(slot(1)), 64'(mk(1'b1, 10'd238, 10'd1, 6'd16)));
    chk("wrap_x81", 64'(slot(0)), 64'(mk(1'b1, 10'd50, 10'd301, 6'd32)));

    // Fill the third slot.
    fire = 1'b0; ship_x = 10'd200; ship_y = 10'd100; ship_dir = 6'd0;
    run_to(89);
    fire = 1'b1;
    run_to(90);
    chk("fill2", 64'(slot(2)), 64'(mk(1'b1, 10'd100, 10'd200, 6'd0)));
    chk("full_cnt", 64'(active_count), 64'd3);
    fire = 1'b0;
    run_to(99);
    fire = 1'b1;
    run_to(100);
    chk("full_drop", 64'(fire_dropped), 64'd1);
    chk("full_cnt2", 64'(active_count), 64'd3);
    fire = 1'b0;
    run_to(101);
    // Kill and spawn on slot1 in the same tick: spawn wins.
    fire = 1'b1; kill_mask = 3'b010;
    ship_x = 10'd150; ship_y = 10'd60; ship_dir = 6'd8;
    run_to(102);
    chk("kill_spawn", 64'(slot(1)), 64'(mk(1'b1, 10'd60, 10'd150, 6'd8)));
    chk("kill_cnt", 64'(active_count), 64'd3);
    chk("kill_nodrop", 64'(fire_dropped), 64'd0);
    fire = 1'b0; kill_mask = 3'b100;
    run_to(103);
    chk("kill_keep", 64'(slot(2)), 64'(mk(1'b0, 10'd100, 10'd224, 6'd0)));
    chk("kill_cnt2", 64'(active_count), 64'd2);
    kill_mask = '0;

    // Asynchronous reset mid-cycle, with no clock edge in between.
    #2 reset_n = 1'b1;
    #1;
    chk("arst_shots", 64'(shots), 64'd0);
    chk("arst_cnt", 64'(active_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
